m68k_bus_sequencer: RTL

//  Sequences one Amiga 68000 bus transaction (byte/word/long) requested by the Pi register interface.

---
 rtl/m68k_bus_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_sequencer.sv
// Runs one 68000 bus transaction (byte/word/long) for the Pi register interface,
// generating E, handling DTACK/BERR/VPA and splitting longs into two word cycles.
module m68k_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int E_DIV          = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        mc_clk_rising,
  input  logic        mc_clk_falling,
  input  logic        req_start,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [2:0]  req_fc,
  input  logic [23:0] req_address,
  input  logic [31:0] req_data_write,
  input  logic        dtack_n,
  input  logic        berr_n,
  input  logic        vpa_n,
  input  logic [15:0] d_in,
  output logic [22:0] a_out,
  output logic [15:0] d_out,
  output logic [2:0]  fc_out,
  output logic        rnw_out,
  output logic        as_n,
  output logic        uds_n,
  output logic        lds_n,
  output logic        vma_n,
  output logic        e_clk,
  output logic        bus_drive,
  output logic        dbus_drive,
  output logic        req_active,
  output logic        req_ok,
  output logic [31:0] req_data_read
);
  localparam int EW = (E_DIV > 2) ? $clog2(E_DIV) : 2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [EW-1:0] E_LAST = EW'(E_DIV - 1);
  localparam logic [EW-1:0] E_VMA  = EW'(2);
  localparam logic [EW-1:0] E_HIGH = EW'((E_DIV * 6) / 10);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, REJECT, ARM, S0, S1, S2, S3, S4, ECYC, S5, S6, S7, ABORT
  } state_t;

  state_t      state;
  logic [EW-1:0] e_cnt;
  logic [EW-1:0] e_next;
  logic [TW-1:0] wait_cnt;
  logic        rw_l;
  logic [1:0]  size_l;
  logic [2:0]  fc_l;
  logic [23:0] addr_l;
  logic [31:0] wdata_l;
  logic        second_half;
  logic        upper_lane;
  logic        lower_lane;
  logic [15:0] write_word;

  assign e_next = (e_cnt == E_LAST) ? '0 : e_cnt + 1'b1;

  // Free-running E generator, stepped by the 7M falling edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      e_cnt <= '0;
      e_clk <= 1'b0;
    end else if (mc_clk_falling) begin
      e_cnt <= e_next;
      e_clk <= (e_next >= E_HIGH);
    end
  end

  always_comb begin
    upper_lane = (size_l != 2'd0) || !addr_l[0];
    lower_lane = (size_l != 2'd0) || addr_l[0];
    write_word = wdata_l[15:0];
    if (size_l == 2'd0)
      write_word = {wdata_l[7:0], wdata_l[7:0]};
    else if (size_l == 2'd2 && !second_half)
      write_word = wdata_l[31:16];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      rw_l          <= 1'b1;
      size_l        <= 2'd0;
      fc_l          <= 3'd0;
      addr_l        <= 24'd0;
      wdata_l       <= 32'd0;
      second_half   <= 1'b0;
      a_out         <= 23'd0;
      d_out         <= 16'd0;
      fc_out        <= 3'd0;
      rnw_out       <= 1'b1;
      as_n          <= 1'b1;
      uds_n         <= 1'b1;
      lds_n         <= 1'b1;
      vma_n         <= 1'b1;
      bus_drive     <= 1'b0;
      dbus_drive    <= 1'b0;
      req_active    <= 1'b0;
      req_ok        <= 1'b0;
      req_data_read <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_start) begin
          rw_l        <= req_rw;
          size_l      <= req_size;
          fc_l        <= req_fc;
          addr_l      <= req_address;
          wdata_l     <= req_data_write;
          second_half <= 1'b0;
          req_active  <= 1'b1;
          req_ok      <= 1'b0;
          if (req_size == 2'd3 || (req_size != 2'd0 && req_address[0]))
            state <= REJECT;
          else
            state <= ARM;
        end
        REJECT: begin
          req_active <= 1'b0;
          state      <= IDLE;
        end
        ARM: if (mc_clk_rising) begin
          bus_drive <= 1'b1;
          fc_out    <= fc_l;
          rnw_out   <= 1'b1;
          state     <= S0;
        end
        S0: if (mc_clk_falling) begin
          a_out <= addr_l[23:1];
          state <= S1;
        end
        S1: if (mc_clk_rising) begin
          as_n <= 1'b0;
          if (rw_l) begin
            uds_n <= !upper_lane;
            lds_n <= !lower_lane;
          end else begin
            rnw_out    <= 1'b0;
            dbus_drive <= 1'b1;
            d_out      <= write_word;
          end
          state <= S2;
        end
        S2: if (mc_clk_falling) begin
          if (!rw_l) begin
            uds_n <= !upper_lane;
            lds_n <= !lower_lane;
          end
          state <= S3;
        end
        S3: if (mc_clk_rising) begin
          wait_cnt <= '0;
          state    <= S4;
        end
        // BERR outranks DTACK, which outranks VPA; silence counts toward timeout.
        S4: if (mc_clk_falling) begin
          if (!berr_n || (dtack_n && vpa_n && wait_cnt == T_LAST)) begin
            as_n  <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
            vma_n <= 1'b1;
            state <= ABORT;
          end else if (!dtack_n) begin
            state <= S5;
          end else if (!vpa_n) begin
            state <= ECYC;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ECYC: if (mc_clk_falling) begin
          if (vma_n && e_cnt == E_VMA)
            vma_n <= 1'b0;
          else if (!vma_n && e_cnt == E_LAST)
            state <= S5;
        end
        S5: if (mc_clk_rising) state <= S6;
        S6: if (mc_clk_falling) begin
          as_n  <= 1'b1;
          uds_n <= 1'b1;
          lds_n <= 1'b1;
          vma_n <= 1'b1;
          if (rw_l) begin
            case (size_l)
              2'd0:    req_data_read <= {24'd0, addr_l[0] ? d_in[7:0] : d_in[15:8]};
              2'd1:    req_data_read <= {16'd0, d_in};
              default: begin
                if (second_half) req_data_read[15:0] <= d_in;
                else             req_data_read       <= {d_in, 16'd0};
              end
            endcase
          end
          state <= S7;
        end
        S7: if (mc_clk_rising) begin
          dbus_drive <= 1'b0;
          rnw_out    <= 1'b1;
          if (size_l == 2'd2 && !second_half) begin
            second_half <= 1'b1;
            addr_l      <= addr_l + 24'd2;
            state       <= S0;
          end else begin
            bus_drive  <= 1'b0;
            req_active <= 1'b0;
            req_ok     <= 1'b1;
            state      <= IDLE;
          end
        end
        ABORT: if (mc_clk_rising) begin
          bus_drive  <= 1'b0;
          dbus_drive <= 1'b0;
          rnw_out    <= 1'b1;
          req_active <= 1'b0;
          req_ok     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
